sub4_serial: RTL and testbench
==============================

Name: sub4_serial

Overview:
- Bit-serial subtractor, the inverse companion to the 4-bit ripple adder (fa4) datapath.
- Computes d = a - b - bi, one bit per clock, LSB first, through a single 1-bit full-subtractor cell and a registered borrow.
- Accepts operands on a start pulse and reports the difference and borrow-out with a one-cycle done pulse.
- Benches check it against the combinational adder in two's-complement form: a + ~b + ~bi.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range is 2 or more.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled only on an accepted start.
- b  input  WIDTH  subtrahend; sampled only on an accepted start.
- bi  input  1  borrow-in; sampled only on an accepted start.
- d  output  WIDTH  difference; stable from done until the next accepted start.
- bo  output  1  borrow-out; 1 when a < b + bi (unsigned).
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when d and bo become valid.

Behaviour:
- Reset:
  - rst_n sampled low on a clk edge puts the state in IDLE.
  - Clears d, bo, busy, done, the borrow register, the operand shift registers and the bit counter.
  - Reset mid-RUN aborts the operation with no done pulse; the operand is lost.
- FSM states: IDLE and RUN.
  - IDLE to RUN: start=1 at edge k.
    - a and b load into shift registers; bi loads into the borrow register.
    - Counter clears to 0; busy=1 after edge k.
  - RUN, each edge:
    - Cell inputs are x=a_sr[0], y=b_sr[0], z=borrow.
    - Difference bit = x^y^z; it shifts into d_sr from the MSB side.
    - Next borrow = (~x&y) | (~x&z) | (y&z).
    - a_sr and b_sr shift right; counter increments.
  - RUN to IDLE: on the edge where counter == WIDTH-1.
    - d <= final d_sr; bo <= final borrow.
    - done <= 1; busy <= 0.
- Latency: start accepted at edge k gives done=1 after edge k+WIDTH, i.e. WIDTH cycles; 4 for the default.
- done is high for exactly one cycle, then deasserts.
- d and bo:
  - Outputs update only at completion; intermediate shift state is never visible on d.
  - Both hold their values through IDLE until the next completion.
- start while busy=1 is ignored. No queuing, and a/b/bi changes are not observed.
- start in the same cycle done=1 is accepted (state is IDLE): back-to-back throughput is one result per WIDTH cycles.
- Arithmetic is exact mod 2^WIDTH: {bo,d} == {1'b0,a} - {1'b0,b} - bi, interpreted as a (WIDTH+1)-bit two's-complement result.
- Boundaries:
  - a=b, bi=0 gives d=0, bo=0.
  - a=0, b=0, bi=1 gives all-ones d with bo=1.
  - Max borrow chain: a=0, b=all-ones, bi=1 gives d=0, bo=1.

Optional Feature:
- Macro: SUB4_SERIAL_OVF_EN.
- Defined:
  - Adds output port ov (1 bit), reset 0.
  - Updated with d at completion: ov = (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]). This is the signed-subtraction overflow; bi is included in d.
  - Requires latching a[MSB] and b[MSB] at start.
- Undefined: no ov port, no MSB latches; all other behaviour is identical.

Decomposition:
- Package sub4_serial_pkg holds:
  - the state enum (S_IDLE, S_RUN);
  - the default width constant SUB_W = 4;
  - the counter width function, clog2 of WIDTH.
- One natural sub-module: fs1_cell, a combinational 1-bit full subtractor.
  - Ports x, y, bin, diff, bout.
  - Instantiated once in sub4_serial; reusable in a parallel ripple subtractor.

Test Plan:
- Reset low 2 cycles, then release:
  - d=0, bo=0, busy=0, done=0.
  - With SUB4_SERIAL_OVF_EN, ov=0.
- a=9, b=3, bi=0, start pulse:
  - busy high 4 cycles; done pulses once 4 cycles after start.
  - d=6, bo=0; values held 10 idle cycles.
- a=3, b=9, bi=0 → d=10, bo=1.
- a=0, b=0, bi=1 → d=15, bo=1.
- a=0, b=15, bi=1 → d=0, bo=1.
- Start ignored while busy: start a=9, b=3, then start a=1, b=1 two cycles later → single done with d=6.
- Back-to-back start asserted on the done cycle → second result is correct 4 cycles later.
- Reset mid-RUN after 2 bits: no done pulse; d, bo cleared; next operation a=5, b=2 → d=3, bo=0.
- With SUB4_SERIAL_OVF_EN:
  - a=8, b=1 → d=7, ov=1.
  - a=7, b=15 → d=8, bo=1, ov=1.
  - a=6, b=2 → d=4, ov=0.
- 10 $random {bi,a,b} vectors: compare {bo,d} against the parallel fa4 result a + ~b + ~bi with carry inverted; all must match.

Source files
------------

// File: rtl/sub4_serial_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package sub4_serial_pkg;

   localparam int SUB_W = 4;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // Bit counter width: ceil(log2(width)), never below one bit.
   function automatic int cnt_w(input int width);
      int n;
      n = 1;
      while (int'(32'd1 << n) < width) begin
         n = n + 1;
      end
      return n;
   endfunction

endpackage

// File: rtl/fs1_cell.sv
// Combinational 1-bit full subtractor: diff = x - y - bin, with borrow-out.
module fs1_cell (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = x ^ y ^ bin;
   assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/sub4_serial.sv
// Bit-serial subtractor d = a - b - bi, LSB first, one bit per clock.
// Optional signed-overflow output ov is enabled by defining SUB4_SERIAL_OVF_EN.
module sub4_serial
   import sub4_serial_pkg::*;
#(
   parameter int WIDTH = SUB_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bi,
   output logic [WIDTH-1:0] d,
   output logic             bo,
   output logic             busy,
   output logic             done
`ifdef SUB4_SERIAL_OVF_EN
   ,
   output logic             ov
`endif
);

   localparam int              CNT_W    = cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t             state_r;
   state_t             state_nxt_s;
   logic [WIDTH-1:0]   a_sr_r;
   logic [WIDTH-1:0]   b_sr_r;
   logic [WIDTH-2:0]   d_sr_r;
   logic [WIDTH-1:0]   d_cat_s;
   logic               borrow_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               diff_s;
   logic               bout_s;
   logic               load_s;
   logic               shift_s;
   logic               last_s;
`ifdef SUB4_SERIAL_OVF_EN
   logic               a_msb_r;
   logic               b_msb_r;
`endif

   fs1_cell u_cell (
      .x    (a_sr_r[0]),
      .y    (b_sr_r[0]),
      .bin  (borrow_r),
      .diff (diff_s),
      .bout (bout_s)
   );

   // d_sr only keeps the WIDTH-1 earlier bits; the current bit completes the word.
   assign d_cat_s = {diff_s, d_sr_r};

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_nxt_s = S_RUN;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_RUN: begin
            if (last_s) begin
               state_nxt_s = S_IDLE;
            end else begin
               state_nxt_s = S_RUN;
            end
         end
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // Control strobes derived from the current state.
   always_comb begin
      load_s  = 1'b0;
      shift_s = 1'b0;
      last_s  = 1'b0;
      case (state_r)
         S_IDLE: begin
            load_s = start;
         end
         S_RUN: begin
            shift_s = 1'b1;
            last_s  = (cnt_r == CNT_LAST);
         end
         default: begin
            load_s  = 1'b0;
            shift_s = 1'b0;
            last_s  = 1'b0;
         end
      endcase
   end

   // Operand shift registers, borrow and bit counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sr_r   <= '0;
         b_sr_r   <= '0;
         d_sr_r   <= '0;
         borrow_r <= 1'b0;
         cnt_r    <= '0;
`ifdef SUB4_SERIAL_OVF_EN
         a_msb_r  <= 1'b0;
         b_msb_r  <= 1'b0;
`endif
      end else if (load_s) begin
         a_sr_r   <= a;
         b_sr_r   <= b;
         borrow_r <= bi;
         cnt_r    <= '0;
`ifdef SUB4_SERIAL_OVF_EN
         a_msb_r  <= a[WIDTH-1];
         b_msb_r  <= b[WIDTH-1];
`endif
      end else if (shift_s) begin
         a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
         b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
         d_sr_r   <= d_cat_s[WIDTH-1:1];
         borrow_r <= bout_s;
         cnt_r    <= cnt_r + CNT_W'(1);
      end
   end

   // Result and status outputs; d/bo only change on the final bit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         d    <= '0;
         bo   <= 1'b0;
         done <= 1'b0;
         busy <= 1'b0;
`ifdef SUB4_SERIAL_OVF_EN
         ov   <= 1'b0;
`endif
      end else begin
         done <= last_s;
         busy <= (state_nxt_s == S_RUN);
         if (last_s) begin
            d  <= d_cat_s;
            bo <= bout_s;
`ifdef SUB4_SERIAL_OVF_EN
            ov <= (a_msb_r != b_msb_r) && (diff_s != a_msb_r);
`endif
         end
      end
   end

endmodule

// File: tb/tb_sub4_serial.sv
// Self-checking bench for sub4_serial: directed table, corner sequences, random vs model.
module tb_sub4_serial;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] a;
   logic [3:0] b;
   logic       bi;
   logic [3:0] d;
   logic       bo;
   logic       busy;
   logic       done;
`ifdef SUB4_SERIAL_OVF_EN
   logic       ov;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       bi;
      logic [3:0] d;
      logic       bo;
      logic       ov;
   } vec_t;

   vec_t vecs[9];

   sub4_serial #(.WIDTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .bi    (bi),
      .d     (d),
      .bo    (bo),
      .busy  (busy),
      .done  (done)
`ifdef SUB4_SERIAL_OVF_EN
      ,
      .ov    (ov)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int va, input int vb, input int vbi,
                               input int vd, input int vbo, input int vov);
      vec_t v;
      v.a  = 4'(va);
      v.b  = 4'(vb);
      v.bi = 1'(vbi);
      v.d  = 4'(vd);
      v.bo = 1'(vbo);
      v.ov = 1'(vov);
      return v;
   endfunction

   // Reference: parallel adder in two's-complement form, carry inverted gives borrow.
   function automatic logic [4:0] ref_sub(input logic [3:0] ra, input logic [3:0] rb, input logic rbi);
      logic [4:0] s;
      s = {1'b0, ra} + {1'b0, ~rb} + {4'b0000, ~rbi};
      return {~s[4], s[3:0]};
   endfunction

   // Reference: signed result out of the 4-bit range.
   function automatic logic ref_ov(input logic [3:0] ra, input logic [3:0] rb, input logic rbi);
      int sa, sb, r;
      sa = ra[3] ? int'(ra) - 16 : int'(ra);
      sb = rb[3] ? int'(rb) - 16 : int'(rb);
      r  = sa - sb - int'(rbi);
      return (r < -8) || (r > 7);
   endfunction

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic start_op(input logic [3:0] sa, input logic [3:0] sb, input logic sbi);
      start = 1'b1;
      a     = sa;
      b     = sb;
      bi    = sbi;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int cyc, output int busy_cnt);
      cyc      = 0;
      busy_cnt = 0;
      while (!done && cyc < 20) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic run_and_check(input string tag, input vec_t v);
      int cyc, bc;
      start_op(v.a, v.b, v.bi);
      wait_done(cyc, bc);
      check({tag, "_latency"}, cyc, 4);
      check({tag, "_busy_cycles"}, bc, 4);
      check({tag, "_d"}, int'(d), int'(v.d));
      check({tag, "_bo"}, int'(bo), int'(v.bo));
`ifdef SUB4_SERIAL_OVF_EN
      check({tag, "_ov"}, int'(ov), int'(v.ov));
`endif
   endtask

   initial begin
      int cyc, bc, dones, mism;
      logic [3:0] seen_d;
      logic [3:0] ra, rb;
      logic       rbi;
      logic [4:0] exp5;

      rst_n = 1'b0;
      start = 1'b0;
      a     = 4'd0;
      b     = 4'd0;
      bi    = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_d", int'(d), 0);
      check("rst_bo", int'(bo), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
`ifdef SUB4_SERIAL_OVF_EN
      check("rst_ov", int'(ov), 0);
`endif

      vecs[0] = mk(9, 3, 0, 6, 0, 1);
      vecs[1] = mk(3, 9, 0, 10, 1, 1);
      vecs[2] = mk(0, 0, 1, 15, 1, 0);
      vecs[3] = mk(0, 15, 1, 0, 1, 0);
      vecs[4] = mk(11, 11, 0, 0, 0, 0);
      vecs[5] = mk(8, 1, 0, 7, 0, 1);
      vecs[6] = mk(7, 15, 0, 8, 1, 1);
      vecs[7] = mk(6, 2, 0, 4, 0, 0);
      vecs[8] = mk(15, 0, 1, 14, 0, 0);

      for (int i = 0; i < 9; i++) begin
         run_and_check($sformatf("vec%0d", i), vecs[i]);
         @(negedge clk);
         check($sformatf("vec%0d_done_pulse", i), int'(done), 0);
         if (i == 0) begin
            mism = 0;
            repeat (10) begin
               if (d !== 4'd6 || bo !== 1'b0 || done !== 1'b0 || busy !== 1'b0) mism++;
               @(negedge clk);
            end
            check("hold_idle", mism, 0);
         end
      end

      // start while busy must be ignored
      start_op(4'd9, 4'd3, 1'b0);
      @(negedge clk);
      start = 1'b1;
      a     = 4'd1;
      b     = 4'd1;
      bi    = 1'b0;
      @(negedge clk);
      start = 1'b0;
      dones  = 0;
      seen_d = 4'd0;
      repeat (12) begin
         if (done) begin
            dones++;
            seen_d = d;
         end
         @(negedge clk);
      end
      check("busy_ignore_dones", dones, 1);
      check("busy_ignore_d", int'(seen_d), 6);

      // back-to-back: second start on the done cycle
      start_op(4'd12, 4'd5, 1'b0);
      wait_done(cyc, bc);
      check("b2b_first_d", int'(d), 7);
      start_op(4'd2, 4'd7, 1'b1);
      wait_done(cyc, bc);
      check("b2b_second_latency", cyc, 4);
      check("b2b_second_d", int'(d), 10);
      check("b2b_second_bo", int'(bo), 1);

      // reset in the middle of a run
      start_op(4'd9, 4'd3, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst_d", int'(d), 0);
      check("midrst_bo", int'(bo), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_done", int'(done), 0);
      dones = 0;
      repeat (6) begin
         if (done) dones++;
         @(negedge clk);
      end
      check("midrst_no_done", dones, 0);
      run_and_check("after_rst", mk(5, 2, 0, 3, 0, 0));
      @(negedge clk);

      // random vectors against the model
      for (int k = 0; k < 10; k++) begin
         ra   = 4'($urandom_range(0, 15));
         rb   = 4'($urandom_range(0, 15));
         rbi  = 1'($urandom_range(0, 1));
         exp5 = ref_sub(ra, rb, rbi);
         start_op(ra, rb, rbi);
         wait_done(cyc, bc);
         check($sformatf("rand%0d_a%0d_b%0d_bi%0d_bo_d", k, ra, rb, rbi), int'({bo, d}), int'(exp5));
         check($sformatf("rand%0d_latency", k), cyc, 4);
`ifdef SUB4_SERIAL_OVF_EN
         check($sformatf("rand%0d_ov", k), int'(ov), int'(ref_ov(ra, rb, rbi)));
`endif
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
